// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: instruction field positions,
// opcode values, the illegal-opcode set, limits and FSM state encoding.
package program_loader_pkg;

  // Instruction word field positions
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int SEL_A_MSB  = 10;
  localparam int SEL_A_LSB  = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;
  localparam int SEL_B_MSB  = 7;
  localparam int SEL_B_LSB  = 5;
  localparam int SEL_D_MSB  = 4;
  localparam int SEL_D_LSB  = 2;

  // ALU opcode values
  typedef enum logic [4:0] {
    OP_ADD     = 5'd0,
    OP_SUB     = 5'd1,
    OP_NOT     = 5'd2,
    OP_AND     = 5'd3,
    OP_OR      = 5'd4,
    OP_XOR     = 5'd5,
    OP_SHL     = 5'd6,
    OP_SHR     = 5'd7,
    OP_CMP     = 5'd8,
    OP_LD      = 5'd9,
    OP_ST      = 5'd10,
    OP_MOV     = 5'd11,
    OP_JMP     = 5'd12,
    OP_JMP_REG = 5'd13
  } opcode_t;

  // Opcode groups (opcode[4:1]) that the core cannot execute
  localparam logic [3:0] ILLEGAL_GROUP_0 = 4'd6;
  localparam logic [3:0] ILLEGAL_GROUP_1 = 4'd7;
  localparam logic [3:0] ILLEGAL_GROUP_2 = 4'd14;
  localparam logic [3:0] ILLEGAL_GROUP_3 = 4'd15;

  // Largest program a single session can load
  localparam logic [4:0] MAX_LENGTH = 5'd16;

  // Loader FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic is_illegal_opcode(input logic [4:0] opcode);
    logic [3:0] group;
    group = opcode[4:1];
    return (group == ILLEGAL_GROUP_0) || (group == ILLEGAL_GROUP_1) ||
           (group == ILLEGAL_GROUP_2) || (group == ILLEGAL_GROUP_3);
  endfunction

endpackage

// File: rtl/program_loader_instruction_encoder.sv
// Packs the instruction fields into one 16-bit program word and flags
// opcodes that must never reach program RAM.
module instruction_encoder
  import program_loader_pkg::*;
(
  input  logic [4:0]  alu_opcode,
  input  logic [2:0]  select_a,
  input  logic [2:0]  select_b,
  input  logic [2:0]  select_d,
  input  logic [7:0]  immediate,
  input  logic        imm_format,
  output logic [15:0] word,
  output logic        illegal
);

  // Immediate format carries the 8-bit constant in the low byte; register
  // format carries B and D there with the two lowest bits left at zero.
  always_comb begin
    word = '0;
    word[OPCODE_MSB:OPCODE_LSB] = alu_opcode;
    word[SEL_A_MSB:SEL_A_LSB]   = select_a;
    if (imm_format) begin
      word[IMM_MSB:IMM_LSB] = immediate;
    end else begin
      word[SEL_B_MSB:SEL_B_LSB] = select_b;
      word[SEL_D_MSB:SEL_D_LSB] = select_d;
    end
    illegal = is_illegal_opcode(alu_opcode);
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: accepts instruction fields, encodes them, writes them to
// consecutive program RAM words, then reads them back and checks an XOR
// signature while holding the CPU off.
module program_loader
  import program_loader_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_start,
  input  logic [3:0]  I_base_addr,
  input  logic [4:0]  I_length,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [4:0]  I_alu_opcode,
  input  logic [2:0]  I_select_A,
  input  logic [2:0]  I_select_B,
  input  logic [2:0]  I_select_D,
  input  logic [7:0]  I_immediate,
  input  logic        I_imm_format,
  output logic        O_ram_wr_enable,
  output logic [3:0]  O_ram_addr,
  output logic [15:0] O_ram_data,
  input  logic [15:0] I_ram_data,
  output logic        O_cpu_hold,
  output logic        O_done,
  output logic [1:0]  O_error
);

  logic [1:0]  state;
  logic [3:0]  base_addr;
  logic [3:0]  write_addr;
  logic [4:0]  word_count;
  logic [4:0]  load_count;
  logic [4:0]  verify_count;
  logic [15:0] write_xor;
  logic [15:0] read_xor;
  logic [15:0] enc_word;
  logic        enc_illegal;
  logic [4:0]  start_length;
  logic        accept;

  instruction_encoder u_encoder (
    .alu_opcode (I_alu_opcode),
    .select_a   (I_select_A),
    .select_b   (I_select_B),
    .select_d   (I_select_D),
    .immediate  (I_immediate),
    .imm_format (I_imm_format),
    .word       (enc_word),
    .illegal    (enc_illegal)
  );

  assign start_length = (I_length > MAX_LENGTH) ? MAX_LENGTH : I_length;
  assign O_ready      = (state == ST_LOAD) && (load_count < word_count);
  assign accept       = I_valid && O_ready;
  assign O_cpu_hold   = (state == ST_LOAD) || (state == ST_VERIFY);
  assign O_done       = (state == ST_DONE);

  // Session FSM: the write strobe is registered one cycle after acceptance,
  // so LOAD is left only once the last word's strobe cycle has been issued.
  // VERIFY issues one read per cycle and folds in the data one cycle later.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state           <= ST_IDLE;
      base_addr       <= '0;
      write_addr      <= '0;
      word_count      <= '0;
      load_count      <= '0;
      verify_count    <= '0;
      write_xor       <= '0;
      read_xor        <= '0;
      O_ram_wr_enable <= 1'b0;
      O_ram_addr      <= '0;
      O_ram_data      <= '0;
      O_error         <= '0;
    end else begin
      O_ram_wr_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_start) begin
            base_addr    <= I_base_addr;
            write_addr   <= I_base_addr;
            word_count   <= start_length;
            load_count   <= '0;
            verify_count <= '0;
            write_xor    <= '0;
            read_xor     <= '0;
            O_error      <= '0;
            state        <= (start_length == 5'd0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              O_error[0] <= 1'b1;
            end else begin
              O_ram_wr_enable <= 1'b1;
              O_ram_addr      <= write_addr;
              O_ram_data      <= enc_word;
              write_addr      <= write_addr + 4'd1;
              load_count      <= load_count + 5'd1;
              write_xor       <= write_xor ^ enc_word;
            end
          end else if (load_count == word_count) begin
            state        <= ST_VERIFY;
            O_ram_addr   <= base_addr;
            verify_count <= '0;
          end
        end
        ST_VERIFY: begin
          verify_count <= verify_count + 5'd1;
          if (verify_count != 5'd0) begin
            read_xor <= read_xor ^ I_ram_data;
          end
          if (verify_count == word_count) begin
            if ((read_xor ^ I_ram_data) != write_xor) begin
              O_error[1] <= 1'b1;
            end
            state <= ST_DONE;
          end else if ((verify_count + 5'd1) < word_count) begin
            O_ram_addr <= O_ram_addr + 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a one-cycle-latency
// RAM model that can corrupt a chosen readback word.
module tb_program_loader;

  logic        I_clk;
  logic        I_reset;
  logic        I_start;
  logic [3:0]  I_base_addr;
  logic [4:0]  I_length;
  logic        I_valid;
  logic        O_ready;
  logic [4:0]  I_alu_opcode;
  logic [2:0]  I_select_A;
  logic [2:0]  I_select_B;
  logic [2:0]  I_select_D;
  logic [7:0]  I_immediate;
  logic        I_imm_format;
  logic        O_ram_wr_enable;
  logic [3:0]  O_ram_addr;
  logic [15:0] O_ram_data;
  logic [15:0] I_ram_data;
  logic        O_cpu_hold;
  logic        O_done;
  logic [1:0]  O_error;

  logic [15:0] mem [16];
  logic        corrupt_en;
  logic [3:0]  corrupt_addr;
  int          strobe_count;
  logic [3:0]  strobe_addr [256];
  int          checks;
  int          errors;

  program_loader dut (
    .I_clk           (I_clk),
    .I_reset         (I_reset),
    .I_start         (I_start),
    .I_base_addr     (I_base_addr),
    .I_length        (I_length),
    .I_valid         (I_valid),
    .O_ready         (O_ready),
    .I_alu_opcode    (I_alu_opcode),
    .I_select_A      (I_select_A),
    .I_select_B      (I_select_B),
    .I_select_D      (I_select_D),
    .I_immediate     (I_immediate),
    .I_imm_format    (I_imm_format),
    .O_ram_wr_enable (O_ram_wr_enable),
    .O_ram_addr      (O_ram_addr),
    .O_ram_data      (O_ram_data),
    .I_ram_data      (I_ram_data),
    .O_cpu_hold      (O_cpu_hold),
    .O_done          (O_done),
    .O_error         (O_error)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Program RAM model: synchronous write, registered read, optional
  // single-bit corruption of one readback address.
  always @(posedge I_clk) begin
    if (O_ram_wr_enable) begin
      mem[O_ram_addr] <= O_ram_data;
      strobe_addr[strobe_count[7:0]] <= O_ram_addr;
      strobe_count <= strobe_count + 1;
    end
    I_ram_data <= mem[O_ram_addr] ^
                  ((corrupt_en && (O_ram_addr == corrupt_addr)) ? 16'h0004 : 16'h0000);
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] opcode, input logic [2:0] sel_a,
                               input logic [2:0] sel_b, input logic [2:0] sel_d,
                               input logic [7:0] imm, input logic fmt);
    I_alu_opcode = opcode;
    I_select_A   = sel_a;
    I_select_B   = sel_b;
    I_select_D   = sel_d;
    I_immediate  = imm;
    I_imm_format = fmt;
  endtask

  task automatic startSession(input logic [3:0] base, input logic [4:0] len);
    I_start     = 1'b1;
    I_base_addr = base;
    I_length    = len;
    tick();
    I_start = 1'b0;
  endtask

  task automatic sendWord(input logic [4:0] opcode, input logic [2:0] sel_a,
                          input logic [2:0] sel_b, input logic [2:0] sel_d,
                          input logic [7:0] imm, input logic fmt);
    applyStimulus(opcode, sel_a, sel_b, sel_d, imm, fmt);
    I_valid = 1'b1;
    for (int k = 0; k < 20 && !O_ready; k++) tick();
    checkOutput("ready_before_send", {31'd0, O_ready}, 32'd1);
    tick();
    I_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!O_done && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cycles;
    int strobes_before;
    logic [3:0] wrap_addrs [4];

    checks       = 0;
    errors       = 0;
    strobe_count = 0;
    corrupt_en   = 1'b0;
    corrupt_addr = 4'd0;
    I_ram_data   = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    I_reset     = 1'b1;
    I_start     = 1'b0;
    I_base_addr = 4'd0;
    I_length    = 5'd0;
    I_valid     = 1'b0;
    applyStimulus(5'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_ready", {31'd0, O_ready}, 32'd0);
    checkOutput("rst_wr_enable", {31'd0, O_ram_wr_enable}, 32'd0);
    checkOutput("rst_cpu_hold", {31'd0, O_cpu_hold}, 32'd0);
    checkOutput("rst_done", {31'd0, O_done}, 32'd0);
    checkOutput("rst_addr", {28'd0, O_ram_addr}, 32'd0);
    checkOutput("rst_data", {16'd0, O_ram_data}, 32'd0);
    checkOutput("rst_error", {30'd0, O_error}, 32'd0);
    I_reset = 1'b0;
    tick();

    $display("[TB] single immediate word");
    strobes_before = strobe_count;
    startSession(4'd0, 5'd1);
    checkOutput("t1_cpu_hold", {31'd0, O_cpu_hold}, 32'd1);
    sendWord(5'b10000, 3'd1, 3'd0, 3'd0, 8'h0F, 1'b1);
    checkOutput("t1_wr_enable", {31'd0, O_ram_wr_enable}, 32'd1);
    checkOutput("t1_addr", {28'd0, O_ram_addr}, 32'd0);
    checkOutput("t1_data", {16'd0, O_ram_data}, 32'h810F);
    checkOutput("t1_ready_after", {31'd0, O_ready}, 32'd0);
    waitDone(cycles);
    checkOutput("t1_done_latency", cycles, 32'd3);
    checkOutput("t1_error", {30'd0, O_error}, 32'd0);
    checkOutput("t1_hold_at_done", {31'd0, O_cpu_hold}, 32'd0);
    tick();
    checkOutput("t1_done_pulse", {31'd0, O_done}, 32'd0);
    checkOutput("t1_mem0", {16'd0, mem[0]}, 32'h810F);
    checkOutput("t1_strobes", strobe_count - strobes_before, 32'd1);

    $display("[TB] register format word");
    startSession(4'd5, 5'd1);
    sendWord(5'b00001, 3'd2, 3'd3, 3'd4, 8'hFF, 1'b0);
    checkOutput("t2_addr", {28'd0, O_ram_addr}, 32'd5);
    checkOutput("t2_data", {16'd0, O_ram_data}, 32'h0A70);
    waitDone(cycles);
    checkOutput("t2_error", {30'd0, O_error}, 32'd0);
    tick();

    $display("[TB] address wrap");
    wrap_addrs[0] = 4'd14;
    wrap_addrs[1] = 4'd15;
    wrap_addrs[2] = 4'd0;
    wrap_addrs[3] = 4'd1;
    strobes_before = strobe_count;
    startSession(4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      sendWord(5'd0, 3'd0, 3'd0, 3'd0, 8'hA0 + 8'(i), 1'b1);
      checkOutput("t3_wr_enable", {31'd0, O_ram_wr_enable}, 32'd1);
      checkOutput("t3_addr", {28'd0, O_ram_addr}, {28'd0, wrap_addrs[i]});
    end
    waitDone(cycles);
    checkOutput("t3_done_latency", cycles, 32'd6);
    checkOutput("t3_error", {30'd0, O_error}, 32'd0);
    checkOutput("t3_strobes", strobe_count - strobes_before, 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_strobe_order", {28'd0, strobe_addr[8'(strobes_before + i)]},
                  {28'd0, wrap_addrs[i]});
    end
    checkOutput("t3_mem15", {16'd0, mem[15]}, 32'h00A1);
    tick();

    $display("[TB] illegal opcode mid-stream");
    strobes_before = strobe_count;
    startSession(4'd3, 5'd2);
    sendWord(5'd2, 3'd1, 3'd0, 3'd0, 8'h11, 1'b1);
    checkOutput("t4_first_addr", {28'd0, O_ram_addr}, 32'd3);
    sendWord(5'b01100, 3'd1, 3'd0, 3'd0, 8'h22, 1'b1);
    checkOutput("t4_illegal_no_write", {31'd0, O_ram_wr_enable}, 32'd0);
    checkOutput("t4_illegal_error", {30'd0, O_error}, 32'd1);
    sendWord(5'd3, 3'd1, 3'd0, 3'd0, 8'h33, 1'b1);
    checkOutput("t4_next_addr", {28'd0, O_ram_addr}, 32'd4);
    checkOutput("t4_next_data", {16'd0, O_ram_data}, 32'h1933);
    waitDone(cycles);
    checkOutput("t4_error_done", {30'd0, O_error}, 32'd1);
    checkOutput("t4_strobes", strobe_count - strobes_before, 32'd2);
    tick();

    $display("[TB] readback corruption");
    corrupt_en   = 1'b1;
    corrupt_addr = 4'd8;
    startSession(4'd7, 5'd3);
    for (int i = 0; i < 3; i++) begin
      sendWord(5'd4, 3'd0, 3'd0, 3'd0, 8'h40 + 8'(i), 1'b1);
    end
    waitDone(cycles);
    checkOutput("t5_done_latency", cycles, 32'd5);
    checkOutput("t5_error", {30'd0, O_error}, 32'd2);
    corrupt_en = 1'b0;
    tick();

    $display("[TB] zero length");
    strobes_before = strobe_count;
    startSession(4'd0, 5'd0);
    checkOutput("t6_done", {31'd0, O_done}, 32'd1);
    checkOutput("t6_error_cleared", {30'd0, O_error}, 32'd0);
    checkOutput("t6_hold", {31'd0, O_cpu_hold}, 32'd0);
    tick();
    checkOutput("t6_done_pulse", {31'd0, O_done}, 32'd0);
    checkOutput("t6_strobes", strobe_count - strobes_before, 32'd0);

    $display("[TB] length clamp");
    strobes_before = strobe_count;
    startSession(4'd0, 5'd31);
    for (int i = 0; i < 16; i++) begin
      sendWord(5'd0, 3'd0, 3'd0, 3'd0, 8'(i), 1'b1);
    end
    checkOutput("t7_ready_full", {31'd0, O_ready}, 32'd0);
    waitDone(cycles);
    checkOutput("t7_done_latency", cycles, 32'd18);
    checkOutput("t7_error", {30'd0, O_error}, 32'd0);
    checkOutput("t7_strobes", strobe_count - strobes_before, 32'd16);
    tick();

    $display("[TB] start ignored while busy, then reset during load");
    startSession(4'd10, 5'd3);
    sendWord(5'd0, 3'd0, 3'd0, 3'd0, 8'h55, 1'b1);
    checkOutput("t8_addr0", {28'd0, O_ram_addr}, 32'd10);
    I_start     = 1'b1;
    I_base_addr = 4'd2;
    I_length    = 5'd1;
    sendWord(5'd0, 3'd0, 3'd0, 3'd0, 8'h66, 1'b1);
    I_start = 1'b0;
    checkOutput("t8_addr1", {28'd0, O_ram_addr}, 32'd11);
    applyStimulus(5'd0, 3'd0, 3'd0, 3'd0, 8'h77, 1'b1);
    I_valid = 1'b1;
    I_reset = 1'b1;
    tick();
    strobes_before = strobe_count;
    checkOutput("t8_rst_wr_enable", {31'd0, O_ram_wr_enable}, 32'd0);
    checkOutput("t8_rst_ready", {31'd0, O_ready}, 32'd0);
    checkOutput("t8_rst_hold", {31'd0, O_cpu_hold}, 32'd0);
    checkOutput("t8_rst_done", {31'd0, O_done}, 32'd0);
    checkOutput("t8_rst_addr", {28'd0, O_ram_addr}, 32'd0);
    checkOutput("t8_rst_data", {16'd0, O_ram_data}, 32'd0);
    checkOutput("t8_rst_error", {30'd0, O_error}, 32'd0);
    tick();
    I_reset = 1'b0;
    tick();
    tick();
    tick();
    I_valid = 1'b0;
    checkOutput("t8_no_strobes", strobe_count - strobes_before, 32'd0);
    checkOutput("t8_hold_idle", {31'd0, O_cpu_hold}, 32'd0);
    checkOutput("t8_mem10", {16'd0, mem[10]}, 32'h0055);
    checkOutput("t8_mem11", {16'd0, mem[11]}, 32'h0066);
    checkOutput("t8_mem12_kept", {16'd0, mem[12]}, 32'h000C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
